ram_access_ctrl: RTL

Bus-side initiator for the single-port data RAM. It accepts byte, halfword and word load/store requests from the CPU memory stage through a valid/ready handshake. It drives the RAM's enable, write-enable, address and data-in lines, and returns load data sign- or zero-extended. The RAM has no byte enables, so sub-word stores are performed as read-modify-write.

---
 rtl/ram_access_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Load/store initiator for the single-port data RAM; sub-word stores run as read-modify-write.
// Optional alignment checking: define RAM_ACCESS_ALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | ready for a request
// READ    | RAM read; word captured for load result or RMW merge
// WRITE   | RAM write of full or merged word
// RESP    | one-cycle response pulse
module ram_access_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  ram_ena,
   output logic                  ram_wena,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  signed_q, signed_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  req_err;
   logic [7:0]            byte_lane;
   logic [15:0]           half_lane;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] merge_word;

`ifdef RAM_ACCESS_ALIGN_CHECK_EN
   assign req_err = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign req_err = 1'b0;
`endif

   // Size encoding 11 falls into the word path whenever it is not rejected.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_lane = ram_dout[7:0];
         2'd1:    byte_lane = ram_dout[15:8];
         2'd2:    byte_lane = ram_dout[23:16];
         default: byte_lane = ram_dout[31:24];
      endcase
      half_lane = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
      if (size_q[1]) begin
         load_ext = ram_dout;
      end else if (size_q[0]) begin
         load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      end else begin
         load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
      end
   end

   always_comb begin
      merge_word = hold_q;
      if (size_q[1]) begin
         merge_word = wdata_q;
      end else if (size_q[0]) begin
         if (addr_q[1]) merge_word[31:16] = wdata_q[15:0];
         else           merge_word[15:0]  = wdata_q[15:0];
      end else begin
         merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
   assign ram_din   = merge_word;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      signed_d  = signed_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      hold_d    = hold_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_ena   = 1'b0;
      ram_wena  = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_err) begin
                  state_d = S_RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (req_we && req_size[1]) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            ram_ena = 1'b1;
            hold_d  = ram_dout;
            if (we_q) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_RESP;
               rdata_d = load_ext;
               err_d   = 1'b0;
            end
         end
         S_WRITE: begin
            ram_ena  = 1'b1;
            ram_wena = 1'b1;
            state_d  = S_RESP;
            rdata_d  = '0;
            err_d    = 1'b0;
         end
         default: begin
            rsp_valid = 1'b1;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         hold_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         hold_q   <= hold_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule
